// File: rtl/btn_debounce.sv
// Push-button debouncer with registered level output and single-cycle
// press/release strobes. A level change is accepted only after
// DEBOUNCE_CYCLES consecutive identical samples; one opposing sample aborts it.
// Optional auto-repeat strobes while held: define DEBOUNCE_REPEAT_EN.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    StLow,
    StToHigh,
    StHigh,
    StToLow
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Next-state: count consecutive opposing samples, abort on any agreeing one
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (sync_in) begin
          state_d = StToHigh;
          cnt_d   = CntW'(1);
        end
      end
      StToHigh: begin
        if (!sync_in) begin
          state_d = StLow;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!sync_in) begin
          state_d = StToLow;
          cnt_d   = CntW'(1);
        end
      end
      StToLow: begin
        if (sync_in) begin
          state_d = StHigh;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLow;
    endcase
    level_d = (state_d == StHigh) || (state_d == StToLow);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
  logic            first_q, first_d;  // still waiting for the initial delay
  logic            rep_q, rep_d;

  // Repeat timer: runs only while stably high, frozen while a release is pending
  always_comb begin
    rpt_d      = rpt_q;
    first_d    = first_q;
    rep_d      = 1'b0;
    rpt_inc    = rpt_q + 1'b1;
    rpt_target = first_q ? RptW'(REPEAT_DELAY) : RptW'(REPEAT_PERIOD);
    if (rise_d || state_d == StLow) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if (state_q == StHigh) begin
      if (rpt_inc == rpt_target) begin
        rep_d   = 1'b1;
        rpt_d   = '0;
        first_d = 1'b0;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
      rep_q   <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
      rep_q   <= rep_d;
    end
  end

  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed tables/sequences plus a
// randomized run against a run-length reference model.
module tb_btn_debounce;

  localparam int unsigned N = 4;
  localparam int unsigned D = 10;
  localparam int unsigned P = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sync_in = 1'b0;
  logic level_out, rise_pulse, fall_pulse, repeat_pulse;

  int total = 0;
  int bad = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES(N),
    .REPEAT_DELAY   (D),
    .REPEAT_PERIOD  (P)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (sync_in),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: level flips after N consecutive samples differing from it;
  // repeat strobes fire at h = D, D+P, D+2P ... where h counts edges spent
  // stably high since the last accepted press.
  bit m_level;
  int m_run;
  int m_h;
  bit e_rise, e_fall, e_rep;

  function automatic bit rep_expected(input int h);
`ifdef DEBOUNCE_REPEAT_EN
    return (h >= int'(D)) && (((h - int'(D)) % int'(P)) == 0);
`else
    return (h < 0);
`endif
  endfunction

  task automatic mdl_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_h     = 0;
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    e_rep   = 1'b0;
  endtask

  task automatic mdl_step(input bit s);
    bit stable_high;
    stable_high = m_level && (m_run == 0);
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_rep  = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == int'(N)) begin
        m_level = s;
        m_run   = 0;
        if (s) e_rise = 1'b1;
        else   e_fall = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (e_rise) begin
      m_h = 0;
    end else if (stable_high) begin
      m_h++;
      e_rep = rep_expected(m_h);
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"},  level_out,    m_level);
    chk({tag, ".rise"},   rise_pulse,   e_rise);
    chk({tag, ".fall"},   fall_pulse,   e_fall);
    chk({tag, ".repeat"}, repeat_pulse, e_rep);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".level"},  level_out,    1'b0);
    chk({tag, ".rise"},   rise_pulse,   1'b0);
    chk({tag, ".fall"},   fall_pulse,   1'b0);
    chk({tag, ".repeat"}, repeat_pulse, 1'b0);
  endtask

  // Drive one sample, let it be clocked in, then compare against the model
  task automatic step(input bit s, input string tag);
    sync_in = s;
    @(posedge clk);
    #1;
    mdl_step(s);
    chk_model(tag);
  endtask

  typedef struct {
    bit s;
    bit lvl;
    bit rise;
    bit fall;
  } vec_t;

  vec_t tbl[20];
  // release x4, bounce 1,1,1,0,1,1,1,1, release with glitch 0,0,0,1,0,0,0,0
  bit ts[20] = '{0,0,0,0, 1,1,1,0,1,1,1,1, 0,0,0,1,0,0,0,0};
  bit tl[20] = '{1,1,1,0, 0,0,0,0,0,0,0,1, 1,1,1,1,1,1,1,0};
  bit tr[20] = '{0,0,0,0, 0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0};
  bit tf[20] = '{0,0,0,1, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{ts[i], tl[i], tr[i], tf[i]};
    mdl_reset();

    // Reset held with sync_in toggling: everything stays 0
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    for (int i = 0; i < 6; i++) begin
      sync_in = i[0];
      @(posedge clk);
      #1 chk_zero("reset_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, "post_reset");
    for (int i = 0; i < 3; i++) chk("post_reset.level", level_out, 1'b0);

    // Clean press held 20 cycles
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, "press");
      chk("press.level_exp", level_out, k >= int'(N));
      chk("press.rise_exp", rise_pulse, k == int'(N));
      chk("press.fall_exp", fall_pulse, 1'b0);
    end

    // Table: release, bounce, release with glitch
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].s, "table");
      chk($sformatf("tbl%0d.level", i), level_out, tbl[i].lvl);
      chk($sformatf("tbl%0d.rise", i), rise_pulse, tbl[i].rise);
      chk($sformatf("tbl%0d.fall", i), fall_pulse, tbl[i].fall);
    end

    // Reset mid-debounce discards the partial count
    step(1'b1, "mid");
    step(1'b1, "mid");
    rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    mdl_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_zero("mid_reset_hold");
    for (int k = 1; k <= int'(N); k++) begin
      step(1'b1, "mid_after");
      chk("mid_after.rise_exp", rise_pulse, k == int'(N));
      chk("mid_after.level_exp", level_out, k == int'(N));
    end

    // Repeat: hold 30 cycles after the rise, then release
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, "hold");
`ifdef DEBOUNCE_REPEAT_EN
      chk($sformatf("repeat_at+%0d", k), repeat_pulse, (k >= 10) && ((k - 10) % 3 == 0));
`else
      chk($sformatf("repeat_at+%0d", k), repeat_pulse, 1'b0);
`endif
    end
    begin
      bit seen_fall;
      seen_fall = 1'b0;
      for (int k = 0; k < 10 && !seen_fall; k++) begin
        step(1'b0, "drop");
        seen_fall = fall_pulse;
      end
      chk("drop.fall_seen", seen_fall, 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, "after_fall");
      chk("after_fall.repeat_exp", repeat_pulse, 1'b0);
    end

    // Randomized bouncing runs
    begin
      bit v;
      int len;
      v = 1'b0;
      for (int c = 0; c < 3000; ) begin
        len = int'($urandom_range(1, 7));
        if ($urandom_range(0, 9) == 0) len = int'($urandom_range(12, 30));
        for (int j = 0; j < len; j++) step(v, "random");
        c += len;
        v = ~v;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
